// File: rtl/noc_local_tx_if.sv
// Local-port bundle: packet command, payload stream and 4-phase link to the switch.
interface noc_local_tx_if #(
  parameter int WIDTH   = 32,
  parameter int COORD_W = 4,
  parameter int LEN_W   = 8
);
  logic               cmd_valid;
  logic [COORD_W-1:0] cmd_dst_x;
  logic [COORD_W-1:0] cmd_dst_y;
  logic [LEN_W-1:0]   cmd_len;
  logic               cmd_ready;
  logic               pay_valid;
  logic [WIDTH-3:0]   pay_data;
  logic               pay_ready;
  logic               req_o;
  logic [WIDTH-1:0]   flit_o;
  logic               ack_i;

  // Transmitter view
  modport slave (
    input  cmd_valid, cmd_dst_x, cmd_dst_y, cmd_len,
    output cmd_ready,
    input  pay_valid, pay_data,
    output pay_ready,
    output req_o, flit_o,
    input  ack_i
  );

  // Core / switch view
  modport master (
    output cmd_valid, cmd_dst_x, cmd_dst_y, cmd_len,
    input  cmd_ready,
    output pay_valid, pay_data,
    input  pay_ready,
    input  req_o, flit_o,
    output ack_i
  );
endinterface

// File: rtl/noc_local_tx.sv
// Local-port packet transmitter: head/body/tail serialisation over a 4-phase req/ack link.
module noc_local_tx #(
  parameter int WIDTH     = 32,
  parameter int COORD_W   = 4,
  parameter int LocationX = 0,
  parameter int LocationY = 0,
  parameter int LEN_W     = 8,
  parameter int SETUP_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gen_enable,
  noc_local_tx_if.slave lp,
  output logic          busy,
  output logic [15:0]   pkt_count
);

  localparam int HDR_W  = 2 + 4 * COORD_W;
  localparam int LENF_W = WIDTH - HDR_W;
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);

  typedef enum logic [1:0] {P_IDLE, P_HEAD, P_BODY, P_TAIL} pkt_state_t;
  typedef enum logic [1:0] {L_IDLE, L_SETUP, L_REQ, L_RTZ} link_state_t;

  pkt_state_t         p_state_q, p_state_d;
  link_state_t        l_state_q, l_state_d;
  logic [COORD_W-1:0] dst_x_q, dst_x_d;
  logic [COORD_W-1:0] dst_y_q, dst_y_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [3:0]         setup_cnt_q, setup_cnt_d;
  logic [WIDTH-1:0]   flit_q, flit_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               idle_q, idle_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               ack_meta_q, ack_s_q;

  logic cmd_accept;
  logic need_pay;
  logic load;
  logic pay_take;
  logic flit_done;

  // cmd_ready gates a registered idle flag so it stays low throughout reset
  assign lp.cmd_ready = gen_enable & idle_q;
  assign cmd_accept   = lp.cmd_valid & lp.cmd_ready;
  assign need_pay     = (p_state_q == P_BODY) || (p_state_q == P_TAIL);
  assign load         = (l_state_q == L_IDLE) && (p_state_q != P_IDLE) && (!need_pay || lp.pay_valid);
  assign pay_take     = (l_state_q == L_IDLE) && need_pay && lp.pay_valid;
  assign flit_done    = (l_state_q == L_RTZ) && !ack_s_q;

  assign lp.pay_ready = pay_take;
  assign lp.req_o     = req_q;
  assign lp.flit_o    = flit_q;
  assign busy         = busy_q;
  assign pkt_count    = cnt_q;

  // Packet sequencing: advances one flit each time the link completes a 4-phase cycle
  always_comb begin
    p_state_d = p_state_q;
    dst_x_d   = dst_x_q;
    dst_y_d   = dst_y_q;
    len_d     = len_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    case (p_state_q)
      P_IDLE: begin
        if (cmd_accept) begin
          dst_x_d   = lp.cmd_dst_x;
          dst_y_d   = lp.cmd_dst_y;
          len_d     = lp.cmd_len;
          rem_d     = lp.cmd_len;
          busy_d    = 1'b1;
          p_state_d = P_HEAD;
        end
      end
      P_HEAD: begin
        if (flit_done) begin
          if (len_q == '0) begin
            p_state_d = P_IDLE;
            busy_d    = 1'b0;
            cnt_d     = cnt_q + 16'd1;
          end else if (rem_q > LEN_W'(1)) begin
            p_state_d = P_BODY;
          end else begin
            p_state_d = P_TAIL;
          end
        end
      end
      P_BODY: begin
        if (pay_take) begin
          rem_d = rem_q - LEN_W'(1);
        end
        if (flit_done) begin
          p_state_d = (rem_q > LEN_W'(1)) ? P_BODY : P_TAIL;
        end
      end
      P_TAIL: begin
        if (flit_done) begin
          p_state_d = P_IDLE;
          busy_d    = 1'b0;
          cnt_d     = cnt_q + 16'd1;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
    idle_d = (p_state_d == P_IDLE);
  end

  // Link handshake: load, setup margin, req high until ack, return to zero
  always_comb begin
    l_state_d   = l_state_q;
    setup_cnt_d = setup_cnt_q;
    flit_d      = flit_q;
    req_d       = req_q;
    case (l_state_q)
      L_IDLE: begin
        if (load) begin
          case (p_state_q)
            P_HEAD:  flit_d = {(len_q == '0) ? 2'b11 : 2'b01, dst_x_q, dst_y_q,
                               COORD_W'(LocationX), COORD_W'(LocationY), LENF_W'(len_q)};
            P_BODY:  flit_d = {2'b00, lp.pay_data};
            P_TAIL:  flit_d = {2'b10, lp.pay_data};
            default: flit_d = flit_q;
          endcase
          setup_cnt_d = '0;
          l_state_d   = L_SETUP;
        end
      end
      L_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          req_d     = 1'b1;
          l_state_d = L_REQ;
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      L_REQ: begin
        if (ack_s_q) begin
          req_d     = 1'b0;
          l_state_d = L_RTZ;
        end
      end
      L_RTZ: begin
        if (!ack_s_q) begin
          l_state_d = L_IDLE;
        end
      end
      default: l_state_d = L_IDLE;
    endcase
  end

  // State registers and ack synchroniser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state_q   <= P_IDLE;
      l_state_q   <= L_IDLE;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      setup_cnt_q <= '0;
      flit_q      <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      idle_q      <= 1'b0;
      cnt_q       <= '0;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
    end else begin
      p_state_q   <= p_state_d;
      l_state_q   <= l_state_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      setup_cnt_q <= setup_cnt_d;
      flit_q      <= flit_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      idle_q      <= idle_d;
      cnt_q       <= cnt_d;
      ack_meta_q  <= lp.ack_i;
      ack_s_q     <= ack_meta_q;
    end
  end

endmodule
